fsm_table_writer: RTL and testbench

- Programmable lookup-table FSM: the write-side counterpart to our fixed-ROM table FSMs.
- The next-state/output table is held in an internal RAM.
- The table is loaded over a valid/ready write port, committed, then executed against a serial input stream.
- Lets the same FSM hardware run different sequence detectors without resynthesis.

---
 rtl/fsm_table_writer.sv | 122 ++++++++++++
 tb/tb_fsm_table_writer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_table_writer.sv
// Programmable lookup-table FSM: a RAM holding {next_state, z} per {state, x} is loaded
// over a valid/ready port, committed once every entry is written, then stepped by run_en.
module fsm_table_writer #(
   parameter int STATE_W = 2,
   parameter int IN_W    = 1,
   parameter int OUT_W   = 1,
   localparam int ADDR_W = STATE_W + IN_W,
   localparam int DEPTH  = 1 << ADDR_W,
   localparam int DATA_W = STATE_W + OUT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_start,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              load_commit,
   input  logic              run_en,
   input  logic [IN_W-1:0]   x_in,
   output logic [OUT_W-1:0]  z_out,
   output logic [STATE_W-1:0] state_out,
   output logic              table_ok,
   output logic              err,
   output logic [1:0]        mode_dbg
);

   typedef enum logic [1:0] {
      MODE_IDLE = 2'd0,
      MODE_LOAD = 2'd1,
      MODE_RUN  = 2'd2
   } mode_t;

   // Write handshake: a write transfers on any cycle where wr_valid && wr_ready.
   // wr_ready is high exactly while in LOAD; there is no back-pressure inside LOAD.

   mode_t               mode_q, mode_d;
   logic [DEPTH-1:0]    mask_q, mask_d;
   logic [STATE_W-1:0]  state_q, state_d;
   logic [OUT_W-1:0]    z_q, z_d;
   logic                err_q, err_d;

   logic [DATA_W-1:0]   ram_q [DEPTH];

   logic                wr_fire;
   logic [DEPTH-1:0]    mask_with_wr;
   logic [DATA_W-1:0]   entry;

   assign wr_fire      = wr_valid && (mode_q == MODE_LOAD);
   assign mask_with_wr = wr_fire ? (mask_q | (DEPTH'(1) << wr_addr)) : mask_q;
   assign entry        = ram_q[{state_q, x_in}];

   always_comb begin
      mode_d  = mode_q;
      mask_d  = mask_q;
      state_d = state_q;
      z_d     = z_q;
      err_d   = 1'b0;
      if (load_start) begin
         // A fresh load always wins, even over a same-cycle commit.
         mode_d  = MODE_LOAD;
         mask_d  = '0;
         state_d = '0;
         z_d     = '0;
      end else begin
         case (mode_q)
            MODE_LOAD: begin
               mask_d = mask_with_wr;
               if (load_commit) begin
                  if (&mask_with_wr) begin
                     mode_d  = MODE_RUN;
                     state_d = '0;
                     z_d     = '0;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            MODE_RUN: begin
               if (run_en) begin
                  state_d = entry[DATA_W-1:OUT_W];
                  z_d     = entry[OUT_W-1:0];
               end
            end
            default: begin
               mode_d = MODE_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q  <= MODE_IDLE;
         mask_q  <= '0;
         state_q <= '0;
         z_q     <= '0;
         err_q   <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         mask_q  <= mask_d;
         state_q <= state_d;
         z_q     <= z_d;
         err_q   <= err_d;
      end
   end

   // Table storage is deliberately not reset; the mask guards every read.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         ram_q[wr_addr] <= wr_data;
      end
   end

   assign wr_ready  = (mode_q == MODE_LOAD);
   assign table_ok  = (mode_q == MODE_RUN);
   assign state_out = state_q;
   assign z_out     = z_q;
   assign err       = err_q;
   assign mode_dbg  = mode_q;

endmodule

// File: tb/tb_fsm_table_writer.sv
// Directed bench for fsm_table_writer: loads a "1000" detector table, runs it,
// and exercises incomplete commits, hold, restart and asynchronous reset.
module tb_fsm_table_writer;

   logic       clk;
   logic       reset;
   logic       load_start;
   logic       wr_valid;
   logic       wr_ready;
   logic [2:0] wr_addr;
   logic [2:0] wr_data;
   logic       load_commit;
   logic       run_en;
   logic [0:0] x_in;
   logic [0:0] z_out;
   logic [1:0] state_out;
   logic       table_ok;
   logic       err;
   logic [1:0] mode_dbg;

   int total = 0;
   int bad   = 0;

   logic [2:0] tbl [8];

   fsm_table_writer dut (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .load_commit(load_commit),
      .run_en     (run_en),
      .x_in       (x_in),
      .z_out      (z_out),
      .state_out  (state_out),
      .table_ok   (table_ok),
      .err        (err),
      .mode_dbg   (mode_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load_start  = 1'b0;
      wr_valid    = 1'b0;
      wr_addr     = '0;
      wr_data     = '0;
      load_commit = 1'b0;
      run_en      = 1'b0;
      x_in        = '0;
   endtask

   task automatic pulse_load_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic write_entry(input logic [2:0] a, input logic [2:0] d, input logic commit);
      wr_valid    = 1'b1;
      wr_addr     = a;
      wr_data     = d;
      load_commit = commit;
      tick();
      wr_valid    = 1'b0;
      load_commit = 1'b0;
   endtask

   task automatic run_step(input string tag, input logic x, input logic [1:0] exp_s,
                           input logic exp_z);
      run_en = 1'b1;
      x_in   = x;
      tick();
      run_en = 1'b0;
      check({tag, "_state"}, 32'(state_out), 32'(exp_s));
      check({tag, "_z"}, 32'(z_out), 32'(exp_z));
   endtask

   initial begin
      tbl[0] = 3'b000; tbl[1] = 3'b010; tbl[2] = 3'b100; tbl[3] = 3'b010;
      tbl[4] = 3'b110; tbl[5] = 3'b010; tbl[6] = 3'b001; tbl[7] = 3'b010;

      // 1: reset values, writes and commit ignored in IDLE
      idle_inputs();
      reset = 1'b0;
      tick();
      tick();
      check("rst_state", 32'(state_out), 0);
      check("rst_z", 32'(z_out), 0);
      check("rst_table_ok", 32'(table_ok), 0);
      check("rst_err", 32'(err), 0);
      check("rst_wr_ready", 32'(wr_ready), 0);
      reset = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) write_entry(3'(i), tbl[i], 1'b0);
      check("idle_wr_ready", 32'(wr_ready), 0);
      load_commit = 1'b1;
      tick();
      load_commit = 1'b0;
      check("idle_commit_err", 32'(err), 0);
      check("idle_commit_tok", 32'(table_ok), 0);
      pulse_load_start();
      check("load_wr_ready", 32'(wr_ready), 1);
      load_commit = 1'b1;
      tick();
      load_commit = 1'b0;
      check("empty_commit_err", 32'(err), 1);
      check("empty_commit_tok", 32'(table_ok), 0);
      tick();
      check("err_one_cycle", 32'(err), 0);

      // 2: full load and commit
      pulse_load_start();
      for (int i = 0; i < 8; i++) write_entry(3'(i), tbl[i], 1'b0);
      load_commit = 1'b1;
      tick();
      load_commit = 1'b0;
      check("commit_tok", 32'(table_ok), 1);
      check("commit_err", 32'(err), 0);
      check("commit_state", 32'(state_out), 0);
      check("run_wr_ready", 32'(wr_ready), 0);

      // 3: detect 1000
      run_step("seq1", 1'b1, 2'b01, 1'b0);
      run_step("seq2", 1'b0, 2'b10, 1'b0);
      run_step("seq3", 1'b0, 2'b11, 1'b0);
      run_step("seq4", 1'b0, 2'b00, 1'b1);

      // 4: incomplete load (addr5 missing), then finish it with a same-cycle commit
      pulse_load_start();
      check("reload_tok", 32'(table_ok), 0);
      check("reload_z", 32'(z_out), 0);
      for (int i = 0; i < 8; i++) if (i != 5) write_entry(3'(i), tbl[i], 1'b0);
      load_commit = 1'b1;
      tick();
      load_commit = 1'b0;
      check("partial_err", 32'(err), 1);
      check("partial_tok", 32'(table_ok), 0);
      tick();
      check("partial_err_drop", 32'(err), 0);
      check("partial_stay_load", 32'(wr_ready), 1);
      write_entry(3'd5, tbl[5], 1'b1);
      check("samecyc_tok", 32'(table_ok), 1);
      check("samecyc_err", 32'(err), 0);

      // 5: hold with run_en=0 and attempted write during RUN
      run_step("hold_pre1", 1'b1, 2'b01, 1'b0);
      run_step("hold_pre2", 1'b0, 2'b10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         run_en   = 1'b0;
         x_in     = 1'(i);
         wr_valid = 1'b1;
         wr_addr  = 3'd0;
         wr_data  = 3'b111;
         tick();
         check("hold_state", 32'(state_out), 2);
         check("hold_z", 32'(z_out), 0);
      end
      wr_valid = 1'b0;
      run_step("resume1", 1'b0, 2'b11, 1'b0);
      run_step("resume2", 1'b0, 2'b00, 1'b1);
      run_step("ram_intact", 1'b0, 2'b00, 1'b0);

      // 6: restart wins over commit; async reset mid-LOAD
      load_start  = 1'b1;
      load_commit = 1'b1;
      tick();
      load_start  = 1'b0;
      load_commit = 1'b0;
      check("restart_load", 32'(wr_ready), 1);
      check("restart_tok", 32'(table_ok), 0);
      check("restart_state", 32'(state_out), 0);
      check("restart_err", 32'(err), 0);
      for (int i = 0; i < 8; i++) write_entry(3'(i), tbl[i], 1'b0);
      reset = 1'b0;
      #2;
      check("async_rst_ready", 32'(wr_ready), 0);
      check("async_rst_mode", 32'(mode_dbg), 0);
      reset = 1'b1;
      tick();
      pulse_load_start();
      load_commit = 1'b1;
      tick();
      load_commit = 1'b0;
      check("mask_cleared_err", 32'(err), 1);
      check("mask_cleared_tok", 32'(table_ok), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
